// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory and
// captures each returned word into a registered IF/ID slot that decode drains with a
// valid/ready handshake. A redirect from execute reloads the PC. It also flushes the slot
// and discards any outstanding memory response.
//
// Optional feature macro: FETCH_JUMP_EN. When defined, j/jal words are still delivered,
// and the next fetch goes straight to the jump target.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   imem_req_valid/ready       fetch request handshake, imem_addr = current PC
//   imem_rsp_valid/data        returned instruction word (one per accepted request)
//   redirect_valid/pc          taken branch/jump target from execute
//   if_valid/ready             IF/ID slot handshake toward decode
//   if_inst, if_pc, if_pc4     slot contents
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;

  logic        req_fire;
  logic        capture;
  logic [31:0] pc_plus4;
  logic [31:0] seq_pc;
  logic        unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign pc_plus4 = pc_q + 32'd4;

  // Only issue when the slot will be free to take the response.
  assign imem_req_valid = (state_q == StReq) && (!valid_q || if_ready);
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign capture        = (state_q == StWait) && imem_rsp_valid && !drop_q && !redirect_valid;

  always_comb begin
    seq_pc = pc_plus4;
`ifdef FETCH_JUMP_EN
    // j (000010) and jal (000011) differ only in bit 26.
    if (imem_rsp_data[31:27] == 5'b00001) begin
      seq_pc = {pc_plus4[31:28], imem_rsp_data[25:0], 2'b00};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (req_fire) begin
          state_d = StWait;
          // A redirect racing the accept makes the response stale.
          drop_d  = redirect_valid;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          state_d = StReq;
          drop_d  = 1'b0;
        end else if (redirect_valid) begin
          drop_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      valid_d = 1'b1;
      inst_d  = imem_rsp_data;
      ipc_d   = pc_q;
      ipc4_d  = pc_plus4;
      pc_d    = seq_pc;
    end else if (valid_q && if_ready) begin
      valid_d = 1'b0;
    end

    // Redirect wins over everything, including a same-cycle decode handshake.
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= 32'h0;
      ipc_q   <= 32'h0;
      ipc4_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_inst   = inst_q;
  assign if_pc     = ipc_q;
  assign if_pc4    = ipc4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_inst, if_pc, if_pc4;

  logic        req_valid2, rsp_valid2, if_valid2;
  logic [31:0] addr2, if_inst2, if_pc2, if_pc4_2;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4)
  );

  // Second instance starting at the top of the address space, zero-wait memory.
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid2), .imem_req_ready(1'b1), .imem_addr(addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(32'h2400_0001),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(if_valid2), .if_ready(1'b1), .if_inst(if_inst2), .if_pc(if_pc2), .if_pc4(if_pc4_2)
  );

  always @(posedge clk or negedge rst) begin
    if (!rst) rsp_valid2 <= 1'b0;
    else      rsp_valid2 <= req_valid2;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int deliveries = 0;

  int rdy_pct = 100, dec_pct = 100, redir_pct = 0, spur_pct = 0, max_dly = 0;
  bit drv_en = 1'b1;
  int force_req = 0;
  logic [31:0] force_tgt = 32'h0;

  bit          pending = 1'b0;
  int          dly = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] hs_q[$];
  int          deliv_q[$];
  logic [31:0] exp_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory image.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000_0000) return 32'h0800_0040;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  // Program-order successor of an instruction.
  function automatic logic [31:0] next_pc_of(input logic [31:0] pc, input logic [31:0] inst);
    logic [31:0] p4;
    p4 = pc + 32'd4;
`ifdef FETCH_JUMP_EN
    if (inst[31:26] == 6'd2 || inst[31:26] == 6'd3) return {p4[31:28], inst[25:0], 2'b00};
`endif
    return p4;
  endfunction

  // Memory and decode driver; inputs change on the falling edge.
  initial begin : driver
    int force_seen;
    force_seen = 0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!drv_en) begin
        pending = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
      end else begin
        if (pending && dly == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pending        = 1'b0;
        end else begin
          if (pending) dly--;
          imem_rsp_valid = !pending && ($urandom_range(99) < spur_pct);
          imem_rsp_data  = $urandom;
        end
        if_ready       = ($urandom_range(99) < dec_pct);
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        if (force_req != force_seen) begin
          force_seen     = force_req;
          redirect_valid = 1'b1;
          redirect_pc    = force_tgt;
        end else begin
          redirect_valid = ($urandom_range(99) < redir_pct);
          redirect_pc    = $urandom;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
          hs_q.push_back(imem_addr);
          pending   = 1'b1;
          pend_addr = imem_addr;
          dly       = $urandom_range(max_dly);
        end
        #2;
        // After the monitor has consumed this cycle's delivery.
        if (redirect_valid) begin
          exp_q.delete();
          exp_q.push_back({redirect_pc[31:2], 2'b00});
        end
      end
    end
  end

  // Scoreboard monitor on decode handshakes.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && if_valid && if_ready) begin
        deliveries++;
        deliv_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty actual_pc=%h required=none", if_pc);
        end else begin
          e = exp_q.pop_front();
          check32("sb_pc", if_pc, e);
          check32("sb_inst", if_inst, mem_word(e));
          check32("sb_pc4", if_pc4, e + 32'd4);
          exp_q.push_back(next_pc_of(e, mem_word(e)));
        end
      end
    end
  end

  initial begin : main
    bit          seen;
    int          n, d0;
    logic [31:0] stall_addr;
    exp_q.push_back(32'h0);

    // Reset values.
    repeat (3) @(negedge clk);
    #2;
    check32("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check32("rst_addr", imem_addr, 32'h0);
    check32("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check32("rst_if_inst", if_inst, 32'h0);
    check32("rst_if_pc", if_pc, 32'h0);
    check32("rst_if_pc4", if_pc4, 32'h0);
    check32("rst_hi_addr", addr2, 32'hFFFF_FFFC);
    #2 rst = 1'b1;

    // Zero-wait memory, decode always ready; also watch the wrap-around instance.
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      if (if_valid2 && !seen) begin
        seen = 1'b1;
        check32("hi_if_pc", if_pc2, 32'hFFFF_FFFC);
        check32("hi_if_pc4", if_pc4_2, 32'h0);
        check32("hi_next_addr", addr2, 32'h0);
      end
    end
    check32("hi_seen", {31'h0, seen}, 32'h1);
    check32("a_hs_count_ok", {31'h0, hs_q.size() >= 3}, 32'h1);
    check32("a_deliv_count_ok", {31'h0, deliv_q.size() >= 3}, 32'h1);
    if (hs_q.size() >= 3 && deliv_q.size() >= 3) begin
      check32("a_addr0", hs_q[0], 32'h0);
      check32("a_addr1", hs_q[1], 32'h4);
      check32("a_addr2", hs_q[2], 32'h8);
      check32("a_gap1", deliv_q[1] - deliv_q[0], 32'd2);
      check32("a_gap2", deliv_q[2] - deliv_q[1], 32'd2);
    end

    // Decode stall: slot holds, no new request until decode drains.
    #2 dec_pct = 0;
    repeat (6) @(negedge clk);
    #2;
    stall_addr = hs_q[$];
    n = hs_q.size();
    for (int i = 0; i < 3; i++) begin
      check32("b_hold_valid", {31'h0, if_valid}, 32'h1);
      check32("b_hold_inst", if_inst, mem_word(stall_addr));
      check32("b_no_req", {31'h0, imem_req_valid}, 32'h0);
      @(negedge clk);
      #2;
    end
    #2 dec_pct = 100;
    @(negedge clk);
    #2;
    check32("b_drain_req", {31'h0, imem_req_valid}, 32'h1);
    check32("b_drain_valid", {31'h0, if_valid}, 32'h1);
    check32("b_hs_count", hs_q.size(), n + 1);
    check32("b_drain_addr", hs_q[$], next_pc_of(stall_addr, mem_word(stall_addr)));

    // Redirect in WAIT with the response arriving in the same cycle.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #4;
      if (pending && dly == 0) seen = 1'b1;
    end
    check32("c_wait_found", {31'h0, seen}, 32'h1);
    force_tgt = 32'h0000_0103;
    force_req++;
    repeat (2) @(negedge clk);
    #2;
    check32("c_if_valid", {31'h0, if_valid}, 32'h0);
    check32("c_addr", imem_addr, 32'h0000_0100);

    // Jump word at 0x1000_0000.
    #2;
    force_tgt = 32'h1000_0000;
    force_req++;
    @(negedge clk);
    #2;
    n = hs_q.size();
    for (int i = 0; i < 20 && hs_q.size() < n + 2; i++) @(negedge clk);
    #2;
    check32("j_hs_count_ok", {31'h0, hs_q.size() >= n + 2}, 32'h1);
    if (hs_q.size() >= n + 2) begin
      check32("j_addr", hs_q[n], 32'h1000_0000);
`ifdef FETCH_JUMP_EN
      check32("j_next_addr", hs_q[n + 1], 32'h1000_0100);
`else
      check32("j_next_addr", hs_q[n + 1], 32'h1000_0004);
`endif
    end

    // Randomised traffic.
    d0 = deliveries;
    rdy_pct = 70; dec_pct = 70; redir_pct = 5; spur_pct = 20; max_dly = 3;
    repeat (1500) @(negedge clk);
    #2;
    check32("d_progress", {31'h0, (deliveries - d0) > 100}, 32'h1);

    // Asynchronous reset while a response is outstanding.
    rdy_pct = 100; dec_pct = 100; redir_pct = 0; spur_pct = 0; max_dly = 3;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #4;
      if (pending && dly >= 1) seen = 1'b1;
    end
    check32("e_wait_found", {31'h0, seen}, 32'h1);
    drv_en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check32("e_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check32("e_addr", imem_addr, 32'h0);
    check32("e_if_valid", {31'h0, if_valid}, 32'h0);
    check32("e_if_inst", if_inst, 32'h0);
    check32("e_if_pc", if_pc, 32'h0);
    check32("e_if_pc4", if_pc4, 32'h0);
    imem_req_ready = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    #4 rst = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      check32("e_late_rsp_ignored", {31'h0, if_valid}, 32'h0);
    end
    imem_rsp_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
